// File: rtl/add_pkg.sv
// Shared constants for the add datapath primitive.
//   ADD_DEFAULT_N : default operand/sum width
//   ADD_GROUP_W   : width of one carry-lookahead group
package add_pkg;

  localparam int unsigned ADD_DEFAULT_N = 16;
  localparam int unsigned ADD_GROUP_W   = 4;

endpackage : add_pkg

// File: rtl/add_cla4.sv
// Combinational 4-bit carry-lookahead group.
// Ports:
//   a, b : 4-bit operand slices
//   ci   : carry into the group
//   sum  : 4 sum bits
//   p, g : group propagate / generate, for chaining group carries outside
module add_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       p,
  output logic       g
);

  logic [3:0] bit_g;
  logic [3:0] bit_p;
  logic [3:0] carry;

  // Internal carries are fully expanded so no bit waits on a lower one.
  always_comb begin
    bit_g    = a & b;
    bit_p    = a ^ b;
    carry[0] = ci;
    carry[1] = bit_g[0] | (bit_p[0] & ci);
    carry[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & ci);
    carry[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
             | (bit_p[2] & bit_p[1] & bit_p[0] & ci);
    sum      = bit_p ^ carry;
    p        = &bit_p;
    g        = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
             | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
  end

endmodule : add_cla4

// File: rtl/add.sv
// Registered N-bit adder with carry-in, carry-out and signed overflow.
// Sum is formed from N/4 add_cla4 groups whose carries ripple group to group.
// Ports:
//   clock, reset_     : clock and synchronous active-high reset
//   x, y, c_in        : operands and carry-in, qualified by in_valid
//   s, c_out, ovf     : registered sum, unsigned carry-out, signed overflow
//   out_valid         : s/c_out/ovf hold a fresh result this cycle
// Build option ADD_PIPE_EN: registers the low half sum and the mid carry,
// finishing the high half one cycle later (latency 2, needs N >= 8).
module add
  import add_pkg::*;
#(
  parameter int unsigned N = ADD_DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  input  logic         in_valid,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf,
  output logic         out_valid
);

  localparam int unsigned NG   = N / ADD_GROUP_W;
  localparam int          NG_I = int'(NG);
  localparam int          GW   = int'(ADD_GROUP_W);

`ifdef ADD_PIPE_EN
  localparam int          LG   = NG_I / 2;
  localparam int unsigned LW   = 32'(LG) * ADD_GROUP_W;
  localparam int unsigned HW   = N - LW;

  logic [LW-1:0] lo_d, lo_q;
  logic [HW-1:0] xh_d, xh_q;
  logic [HW-1:0] yh_d, yh_q;
  logic          cm_d, cm_q;
  logic          v1_d, v1_q;
`endif

  logic [ADD_GROUP_W-1:0] grp_a [NG];
  logic [ADD_GROUP_W-1:0] grp_b [NG];
  logic [NG-1:0]          grp_p;
  logic [NG-1:0]          grp_g;
  logic [NG-1:0]          grp_ci;
  logic [NG-1:0]          grp_co;
  logic [N-1:0]           sum_w;

  logic [N-1:0] s_d, s_q;
  logic         c_d, c_q;
  logic         o_d, o_q;
  logic         v_d, v_q;

  // Group array: operand source and carry-in selection per group.
  for (genvar k = 0; k < NG_I; k++) begin : g_grp
`ifdef ADD_PIPE_EN
    if (k < LG) begin : g_lo
      assign grp_a[k] = x[GW*k +: GW];
      assign grp_b[k] = y[GW*k +: GW];
    end else begin : g_hi
      assign grp_a[k] = xh_q[GW*(k-LG) +: GW];
      assign grp_b[k] = yh_q[GW*(k-LG) +: GW];
    end
    if (k == LG) begin : g_ci_mid
      assign grp_ci[k] = cm_q;
    end else if (k == 0) begin : g_ci_in
      assign grp_ci[k] = c_in;
    end else begin : g_ci_chain
      assign grp_ci[k] = grp_co[k-1];
    end
`else
    assign grp_a[k] = x[GW*k +: GW];
    assign grp_b[k] = y[GW*k +: GW];
    if (k == 0) begin : g_ci_in
      assign grp_ci[k] = c_in;
    end else begin : g_ci_chain
      assign grp_ci[k] = grp_co[k-1];
    end
`endif

    add_cla4 u_cla4 (
      .a   (grp_a[k]),
      .b   (grp_b[k]),
      .ci  (grp_ci[k]),
      .sum (sum_w[GW*k +: GW]),
      .p   (grp_p[k]),
      .g   (grp_g[k])
    );

    assign grp_co[k] = grp_g[k] | (grp_p[k] & grp_ci[k]);
  end

`ifdef ADD_PIPE_EN
  // Stage 1: capture low-half sum, mid carry and high-half operands.
  always_comb begin
    lo_d = lo_q;
    xh_d = xh_q;
    yh_d = yh_q;
    cm_d = cm_q;
    v1_d = in_valid;
    if (in_valid) begin
      lo_d = sum_w[LW-1:0];
      xh_d = x[N-1:LW];
      yh_d = y[N-1:LW];
      cm_d = grp_co[LG-1];
    end
  end

  // Stage 2: high half completes from stage-1 registers.
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    o_d = o_q;
    v_d = v1_q;
    if (v1_q) begin
      s_d = {sum_w[N-1:LW], lo_q};
      c_d = grp_co[NG-1];
      o_d = (xh_q[HW-1] == yh_q[HW-1]) && (sum_w[N-1] != xh_q[HW-1]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      lo_q <= '0;
      xh_q <= '0;
      yh_q <= '0;
      cm_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      lo_q <= lo_d;
      xh_q <= xh_d;
      yh_q <= yh_d;
      cm_q <= cm_d;
      v1_q <= v1_d;
    end
  end
`else
  // Single stage: whole sum and flags load on a valid edge.
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    o_d = o_q;
    v_d = in_valid;
    if (in_valid) begin
      s_d = sum_w;
      c_d = grp_co[NG-1];
      o_d = (x[N-1] == y[N-1]) && (sum_w[N-1] != x[N-1]);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset_) begin
      s_q <= '0;
      c_q <= 1'b0;
      o_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      o_q <= o_d;
      v_q <= v_d;
    end
  end

  assign s         = s_q;
  assign c_out     = c_q;
  assign ovf       = o_q;
  assign out_valid = v_q;

endmodule : add

// File: tb/tb_add.sv
// Directed-vector bench for add (N=16); build with ADD_PIPE_EN for latency 2.
module tb_add;

`ifdef ADD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        v;
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clock;
  logic        reset_;
  logic [15:0] x;
  logic [15:0] y;
  logic        c_in;
  logic        in_valid;
  logic [15:0] s;
  logic        c_out;
  logic        ovf;
  logic        out_valid;

  int n_chk;
  int n_pass;

  exp_t dl;
  exp_t mdl;

  add #(.N(16)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .x         (x),
    .y         (y),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply one cycle of stimulus with its hand-computed result, then check
  // outputs against the delayed/held expectation after the edge.
  task automatic step(input logic [15:0] xi, input logic [15:0] yi, input logic ci,
                      input logic vi, input logic rst,
                      input logic [15:0] es, input logic ec, input logic eo);
    exp_t cur;
    exp_t head;
    @(negedge clock);
    x        = xi;
    y        = yi;
    c_in     = ci;
    in_valid = vi;
    reset_   = rst;
    cur      = '{v: vi, s: es, c: ec, o: eo};
    @(posedge clock);
    if (rst) begin
      dl  = '0;
      mdl = '0;
    end else begin
      if (LAT == 2) begin
        head = dl;
        dl   = cur;
      end else begin
        head = cur;
      end
      mdl.v = head.v;
      if (head.v) begin
        mdl.s = head.s;
        mdl.c = head.c;
        mdl.o = head.o;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(mdl.v));
    chk("s",         32'(s),         32'(mdl.s));
    chk("c_out",     32'(c_out),     32'(mdl.c));
    chk("ovf",       32'(ovf),       32'(mdl.o));
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    dl       = '0;
    mdl      = '0;
    reset_   = 1'b1;
    x        = '0;
    y        = '0;
    c_in     = 1'b0;
    in_valid = 1'b0;

    // reset state
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);

    // directed arithmetic vectors, issued back to back
    step(16'h0014, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0019, 1'b0, 1'b0);
    step(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    step(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    step(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    step(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    step(16'h0FFF, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // idle: out_valid drops, results hold
    step(16'h5555, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(16'hAAAA, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // three-deep stream, including a half-to-half carry
    step(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h2345, 1'b0, 1'b0);
    step(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    step(16'h8001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // reset mid-stream discards in-flight work
    step(16'h4000, 16'h4000, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    step(16'h1111, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // recovery after reset
    step(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_add
